// File: rtl/mul_share_arbiter.sv
// Round-robin front end sharing one pipelined multiplier between two
// requesters; tags follow each operand pair so products return to their owner.
module mul_share_arbiter #(
  parameter int bw  = 64,
  parameter int LAT = 4
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [bw-1:0] req0_a,
  input  logic [bw-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [bw-1:0] req1_a,
  input  logic [bw-1:0] req1_b,
  output logic [bw-1:0] mul_A,
  output logic [bw-1:0] mul_B,
  input  logic [2*bw-1:0] mul_out,
  output logic          rsp0_valid,
  output logic [2*bw-1:0] rsp0_data,
  output logic          rsp1_valid,
  output logic [2*bw-1:0] rsp1_data
);

  logic ptr_q, ptr_d;
  logic gnt0, gnt1, xfer;

  logic [bw-1:0] a_q, a_d;
  logic [bw-1:0] b_q, b_d;

  logic iss_vld_q, iss_vld_d;
  logic iss_id_q, iss_id_d;

  logic [LAT-1:0] vld_q, vld_d;
  logic [LAT-1:0] id_q, id_d;

  logic hit0, hit1;

  logic r0_vld_q, r0_vld_d;
  logic r1_vld_q, r1_vld_d;
  logic [2*bw-1:0] r0_dat_q, r0_dat_d;
  logic [2*bw-1:0] r1_dat_q, r1_dat_d;

  // ptr_q=0 favours requester 0 when both are valid
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | ~ptr_q);
    gnt1 = req1_valid & (~req0_valid | ptr_q);
    xfer = gnt0 | gnt1;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    ptr_d = ptr_q;
    a_d   = a_q;
    b_d   = b_q;
    unique case (1'b1)
      gnt0: begin
        ptr_d = 1'b1;
        a_d   = req0_a;
        b_d   = req0_b;
      end
      gnt1: begin
        ptr_d = 1'b0;
        a_d   = req1_a;
        b_d   = req1_b;
      end
      default: ;
    endcase
  end

  // The issue tag rides with mul_A/mul_B; the LAT stages below then
  // line up with the multiplier so the last stage matches mul_out.
  always_comb begin
    iss_vld_d = xfer;
    iss_id_d  = gnt1;
    vld_d     = '0;
    id_d      = '0;
    vld_d[0]  = iss_vld_q;
    id_d[0]   = iss_id_q;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  always_comb begin
    hit0     = vld_q[LAT-1] & ~id_q[LAT-1];
    hit1     = vld_q[LAT-1] &  id_q[LAT-1];
    r0_vld_d = hit0;
    r1_vld_d = hit1;
    r0_dat_d = hit0 ? mul_out : r0_dat_q;
    r1_dat_d = hit1 ? mul_out : r1_dat_q;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ptr_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      iss_vld_q <= 1'b0;
      iss_id_q  <= 1'b0;
      vld_q     <= '0;
      id_q      <= '0;
      r0_vld_q  <= 1'b0;
      r1_vld_q  <= 1'b0;
      r0_dat_q  <= '0;
      r1_dat_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      iss_vld_q <= iss_vld_d;
      iss_id_q  <= iss_id_d;
      vld_q     <= vld_d;
      id_q      <= id_d;
      r0_vld_q  <= r0_vld_d;
      r1_vld_q  <= r1_vld_d;
      r0_dat_q  <= r0_dat_d;
      r1_dat_q  <= r1_dat_d;
    end
  end

  assign mul_A      = a_q;
  assign mul_B      = b_q;
  assign rsp0_valid = r0_vld_q;
  assign rsp0_data  = r0_dat_q;
  assign rsp1_valid = r1_vld_q;
  assign rsp1_data  = r1_dat_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a 4-stage
// behavioural multiplier model.
module tb_mul_share_arbiter;

  localparam int BW  = 64;
  localparam int LAT = 4;

  logic CLK = 1'b0;
  logic RESETn = 1'b1;
  logic req0_valid = 1'b0;
  logic req0_ready;
  logic [BW-1:0] req0_a = '0;
  logic [BW-1:0] req0_b = '0;
  logic req1_valid = 1'b0;
  logic req1_ready;
  logic [BW-1:0] req1_a = '0;
  logic [BW-1:0] req1_b = '0;
  logic [BW-1:0] mul_A, mul_B;
  logic [2*BW-1:0] mul_out;
  logic rsp0_valid, rsp1_valid;
  logic [2*BW-1:0] rsp0_data, rsp1_data;

  mul_share_arbiter #(.bw(BW), .LAT(LAT)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .mul_A(mul_A), .mul_B(mul_B), .mul_out(mul_out),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data)
  );

  always #5 CLK = ~CLK;

  logic [2*BW-1:0] p [LAT];
  always @(posedge CLK) begin
    p[0] <= {{BW{1'b0}}, mul_A} * {{BW{1'b0}}, mul_B};
    for (int i = 1; i < LAT; i++) p[i] <= p[i-1];
  end
  assign mul_out = p[LAT-1];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic id;
    logic [2*BW-1:0] data;
    int cyc;
  } rsp_t;

  rsp_t rq[$];
  int n_both = 0;

  always @(negedge CLK) begin
    if (rsp0_valid && rsp1_valid) n_both++;
    if (rsp0_valid) rq.push_back('{1'b0, rsp0_data, cyc});
    if (rsp1_valid) rq.push_back('{1'b1, rsp1_data, cyc});
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic exp_id [16];
  logic [127:0] exp_dat [16];

  task automatic expect_seq(input string tag, input int n, input int t0);
    int b;
    b = 0;
    while (rq.size() < n && b < 40) begin
      step();
      b++;
    end
    repeat (3) step();
    chk({tag, "_cnt"}, rq.size(), n);
    for (int i = 0; i < n && i < rq.size(); i++) begin
      chk($sformatf("%s_id%0d", tag, i), rq[i].id, exp_id[i]);
      chk($sformatf("%s_dat%0d", tag, i), rq[i].data, exp_dat[i]);
      chk($sformatf("%s_cyc%0d", tag, i), rq[i].cyc, t0 + LAT + 1 + i);
    end
    rq.delete();
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    step();
    step();
    RESETn = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int t0;

  initial begin
    #2 RESETn = 1'b0;
    #1;
    chk("rst_mulA", mul_A, 0);
    chk("rst_mulB", mul_B, 0);
    chk("rst_v0", rsp0_valid, 0);
    chk("rst_v1", rsp1_valid, 0);
    chk("rst_d0", rsp0_data, 0);
    chk("rst_d1", rsp1_data, 0);
    step();
    step();
    RESETn = 1'b1;
    step();
    chk("idle_rdy0", req0_ready, 0);
    chk("idle_rdy1", req1_ready, 0);

    // single request
    req0_valid = 1; req0_a = 3; req0_b = 5;
    #1;
    chk("one_rdy0", req0_ready, 1);
    chk("one_rdy1", req1_ready, 0);
    step();
    t0 = cyc;
    req0_valid = 0;
    chk("one_mulA", mul_A, 3);
    chk("one_mulB", mul_B, 5);
    exp_id[0] = 0; exp_dat[0] = 15;
    expect_seq("one", 1, t0);
    chk("one_hold0", rsp0_data, 15);
    chk("one_d1", rsp1_data, 0);

    // contention from reset
    do_reset();
    req0_valid = 1; req0_a = 2; req0_b = 7;
    req1_valid = 1; req1_a = 4; req1_b = 9;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("cont_rdy0_%0d", k), req0_ready, (k % 2) == 0);
      chk($sformatf("cont_rdy1_%0d", k), req1_ready, (k % 2) == 1);
      step();
      if (k == 0) t0 = cyc;
      if (k == 6) req0_valid = 0;
      if (k == 7) req1_valid = 0;
      exp_id[k] = k[0];
      exp_dat[k] = k[0] ? 128'd36 : 128'd14;
    end
    expect_seq("cont", 8, t0);

    // pointer after a lone req1 grant
    req1_valid = 1; req1_a = 5; req1_b = 5;
    #1;
    chk("ptr_lone1", req1_ready, 1);
    step();
    t0 = cyc;
    req1_b = 6;
    req0_valid = 1; req0_a = 3; req0_b = 3;
    #1;
    chk("ptr_both_rdy0", req0_ready, 1);
    chk("ptr_both_rdy1", req1_ready, 0);
    step();
    req0_valid = 0;
    #1;
    chk("ptr_after_rdy1", req1_ready, 1);
    step();
    req1_valid = 0;
    exp_id[0] = 1; exp_dat[0] = 25;
    exp_id[1] = 0; exp_dat[1] = 9;
    exp_id[2] = 1; exp_dat[2] = 30;
    expect_seq("ptr", 3, t0);

    // req1 streaming
    req1_valid = 1;
    for (int i = 1; i <= 8; i++) begin
      req1_a = BW'(i); req1_b = BW'(i + 1);
      #1;
      chk($sformatf("strm_rdy%0d", i), req1_ready, 1);
      step();
      if (i == 1) t0 = cyc;
      exp_id[i-1] = 1;
      exp_dat[i-1] = 128'(i * (i + 1));
    end
    req1_valid = 0;
    expect_seq("strm", 8, t0);

    // widest operands
    req0_valid = 1; req0_a = '1; req0_b = '1;
    #1;
    chk("wide_rdy0", req0_ready, 1);
    step();
    t0 = cyc;
    req0_valid = 0;
    exp_id[0] = 0;
    exp_dat[0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    expect_seq("wide", 1, t0);

    // reset while products are in flight
    req0_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      req0_a = BW'(i); req0_b = BW'(i);
      step();
    end
    req0_valid = 0;
    step();
    step();
    RESETn = 1'b0;
    #1;
    chk("mid_mulA", mul_A, 0);
    chk("mid_v0", rsp0_valid, 0);
    step();
    step();
    RESETn = 1'b1;
    repeat (10) step();
    chk("mid_norsp", rq.size(), 0);
    rq.delete();
    req0_valid = 1; req0_a = 6; req0_b = 7;
    #1;
    chk("post_rdy0", req0_ready, 1);
    step();
    t0 = cyc;
    req0_valid = 0;
    exp_id[0] = 0; exp_dat[0] = 42;
    expect_seq("post", 1, t0);

    chk("onehot", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
